alu_operand_stage: RTL and testbench

Parametrised operand-staging register between decode and execute of the CPU pipeline. Selects ALU operands A/B and store data from register-file reads, immediate and PC according to a 3-bit source code, resolves read-after-write hazards by forwarding from the EX/MEM and MEM/WB write-back paths, and registers the result as the ID/EX operand stage with valid, stall and flush control.

---
 rtl/alu_src_pkg.sv | 26 ++
 rtl/operand_fwd_mux.sv | 48 ++++
 rtl/alu_operand_stage.sv | 117 +++++++++++
 tb/tb_alu_operand_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_src_pkg.sv
// Shared encodings for the ID/EX operand stage: ALU operand source codes
// and forwarding-source reports.
package alu_src_pkg;

  // Operand source code: first name is operand A, second is operand B
  // (R1 = forwarded rs value, R2 = forwarded rt value, IM = immediate,
  // NU = zero, PC = instruction PC).
  typedef enum logic [2:0] {
    SRC_NULL  = 3'b000,
    SRC_R1_R2 = 3'b001,
    SRC_R1_IM = 3'b010,
    SRC_R1_NU = 3'b011,
    SRC_IM_NU = 3'b100,
    SRC_R2_R1 = 3'b101,
    SRC_PC_IM = 3'b110,
    SRC_RSVD  = 3'b111
  } alu_src_e;

  // Which write-back path supplied a register operand.
  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/operand_fwd_mux.sv
// Read-after-write forwarding for one register operand. EX/MEM is the
// younger result, so it wins over MEM/WB when both target the same index.
// Forwarding is compiled in only when ALU_OPERAND_FWD_EN is defined;
// otherwise the raw register-file read passes straight through.
module operand_fwd_mux
  import alu_src_pkg::*;
#(
  parameter int DATA_WID     = 16,
  parameter int REG_ADDR_WID = 4
) (
  input  logic [REG_ADDR_WID-1:0] rd_addr,
  input  logic [DATA_WID-1:0]     rd_data,
  input  logic                    exmem_wr_en,
  input  logic [REG_ADDR_WID-1:0] exmem_wr_addr,
  input  logic [DATA_WID-1:0]     exmem_wr_data,
  input  logic                    memwb_wr_en,
  input  logic [REG_ADDR_WID-1:0] memwb_wr_addr,
  input  logic [DATA_WID-1:0]     memwb_wr_data,
  output logic [DATA_WID-1:0]     fwd_data,
  output fwd_sel_e                fwd_sel
);

`ifdef ALU_OPERAND_FWD_EN
  // Priority compare against the two pending write-backs; index 0 is an
  // ordinary register here, not a hard-wired zero.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs (no latch).
    fwd_data = rd_data;
    fwd_sel  = FWD_NONE;
    if (exmem_wr_en && (exmem_wr_addr == rd_addr)) begin
      fwd_data = exmem_wr_data;
      fwd_sel  = FWD_EXMEM;
    end else if (memwb_wr_en && (memwb_wr_addr == rd_addr)) begin
      fwd_data = memwb_wr_data;
      fwd_sel  = FWD_MEMWB;
    end
  end
`else
  // Forwarding disabled: hazards are resolved by external stalls.
  assign fwd_data = rd_data;
  assign fwd_sel  = FWD_NONE;

  logic unused_fwd;
  assign unused_fwd = ^{rd_addr, exmem_wr_en, exmem_wr_addr, exmem_wr_data,
                        memwb_wr_en, memwb_wr_addr, memwb_wr_data};
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand staging register: forwards rs/rt operands, selects ALU
// operands A/B from forwarded values, immediate and PC, and registers them
// with flush > stall > load priority. Optional macro: ALU_OPERAND_FWD_EN.
module alu_operand_stage
  import alu_src_pkg::*;
#(
  parameter int DATA_WID     = 16,
  parameter int REG_ADDR_WID = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              alu_src,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [REG_ADDR_WID-1:0] rs_addr,
  input  logic [REG_ADDR_WID-1:0] rt_addr,
  input  logic [DATA_WID-1:0]     read_data_A,
  input  logic [DATA_WID-1:0]     read_data_B,
  input  logic [DATA_WID-1:0]     immediate,
  input  logic [DATA_WID-1:0]     pc,
  input  logic                    exmem_wr_en,
  input  logic                    memwb_wr_en,
  input  logic [REG_ADDR_WID-1:0] exmem_wr_addr,
  input  logic [REG_ADDR_WID-1:0] memwb_wr_addr,
  input  logic [DATA_WID-1:0]     exmem_wr_data,
  input  logic [DATA_WID-1:0]     memwb_wr_data,
  output logic [DATA_WID-1:0]     srcdata_a,
  output logic [DATA_WID-1:0]     srcdata_b,
  output logic [DATA_WID-1:0]     memdata,
  output logic                    out_valid,
  output logic [1:0]              fwd_sel_a,
  output logic [1:0]              fwd_sel_b
);

  logic [DATA_WID-1:0] fa, fb;
  fwd_sel_e            fsel_a, fsel_b;
  logic [DATA_WID-1:0] sel_a, sel_b;

  operand_fwd_mux #(.DATA_WID(DATA_WID), .REG_ADDR_WID(REG_ADDR_WID)) u_fwd_a (
    .rd_addr       (rs_addr),
    .rd_data       (read_data_A),
    .exmem_wr_en   (exmem_wr_en),
    .exmem_wr_addr (exmem_wr_addr),
    .exmem_wr_data (exmem_wr_data),
    .memwb_wr_en   (memwb_wr_en),
    .memwb_wr_addr (memwb_wr_addr),
    .memwb_wr_data (memwb_wr_data),
    .fwd_data      (fa),
    .fwd_sel       (fsel_a)
  );

  operand_fwd_mux #(.DATA_WID(DATA_WID), .REG_ADDR_WID(REG_ADDR_WID)) u_fwd_b (
    .rd_addr       (rt_addr),
    .rd_data       (read_data_B),
    .exmem_wr_en   (exmem_wr_en),
    .exmem_wr_addr (exmem_wr_addr),
    .exmem_wr_data (exmem_wr_data),
    .memwb_wr_en   (memwb_wr_en),
    .memwb_wr_addr (memwb_wr_addr),
    .memwb_wr_data (memwb_wr_data),
    .fwd_data      (fb),
    .fwd_sel       (fsel_b)
  );

  // Operand select from the source code; reserved code yields zeros.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    case (alu_src_e'(alu_src))
      SRC_R1_R2: begin sel_a = fa;        sel_b = fb;        end
      SRC_R1_IM: begin sel_a = fa;        sel_b = immediate; end
      SRC_R1_NU: begin sel_a = fa;                           end
      SRC_IM_NU: begin sel_a = immediate;                    end
      SRC_R2_R1: begin sel_a = fb;        sel_b = fa;        end
      SRC_PC_IM: begin sel_a = pc;        sel_b = immediate; end
      default:   ;
    endcase
  end

  // Staging register: flush beats stall, stall beats load; a load of an
  // invalid slot clears the payload so bubbles carry no stale data.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      out_valid <= 1'b0;
      srcdata_a <= '0;
      srcdata_b <= '0;
      memdata   <= '0;
      fwd_sel_a <= '0;
      fwd_sel_b <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      srcdata_a <= '0;
      srcdata_b <= '0;
      memdata   <= '0;
      fwd_sel_a <= '0;
      fwd_sel_b <= '0;
    end else if (!stall) begin
      out_valid <= in_valid;
      if (in_valid) begin
        srcdata_a <= sel_a;
        srcdata_b <= sel_b;
        memdata   <= fb;
        fwd_sel_a <= fsel_a;
        fwd_sel_b <= fsel_b;
      end else begin
        srcdata_a <= '0;
        srcdata_b <= '0;
        memdata   <= '0;
        fwd_sel_a <= '0;
        fwd_sel_b <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: a behavioural model predicts
// each cycle's outputs into a scoreboard queue, which is popped and compared
// after the following rising edge. Tracks ALU_OPERAND_FWD_EN like the RTL.
module tb_alu_operand_stage;

  localparam int DW = 16;
  localparam int AW = 4;

  typedef struct packed {
    logic [2:0]    src;
    logic          vld;
    logic          stl;
    logic          fls;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [DW-1:0] rda;
    logic [DW-1:0] rdb;
    logic [DW-1:0] imm;
    logic [DW-1:0] pcv;
    logic          exen;
    logic [AW-1:0] exad;
    logic [DW-1:0] exdt;
    logic          wben;
    logic [AW-1:0] wbad;
    logic [DW-1:0] wbdt;
  } stim_t;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] m;
    logic [1:0]    sa;
    logic [1:0]    sb;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] alu_src = '0;
  logic in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [AW-1:0] rs_addr = '0, rt_addr = '0;
  logic [DW-1:0] read_data_A = '0, read_data_B = '0, immediate = '0, pc = '0;
  logic exmem_wr_en = 1'b0, memwb_wr_en = 1'b0;
  logic [AW-1:0] exmem_wr_addr = '0, memwb_wr_addr = '0;
  logic [DW-1:0] exmem_wr_data = '0, memwb_wr_data = '0;
  logic [DW-1:0] srcdata_a, srcdata_b, memdata;
  logic out_valid;
  logic [1:0] fwd_sel_a, fwd_sel_b;

  int n_checks = 0;
  int n_fail   = 0;
  out_t exp_q  = '0;
  out_t sb_q[$];

  always #5 clk = ~clk;

  alu_operand_stage #(.DATA_WID(DW), .REG_ADDR_WID(AW)) dut (
    .clk(clk), .rst(rst), .alu_src(alu_src), .in_valid(in_valid),
    .stall(stall), .flush(flush), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .read_data_A(read_data_A), .read_data_B(read_data_B),
    .immediate(immediate), .pc(pc),
    .exmem_wr_en(exmem_wr_en), .memwb_wr_en(memwb_wr_en),
    .exmem_wr_addr(exmem_wr_addr), .memwb_wr_addr(memwb_wr_addr),
    .exmem_wr_data(exmem_wr_data), .memwb_wr_data(memwb_wr_data),
    .srcdata_a(srcdata_a), .srcdata_b(srcdata_b), .memdata(memdata),
    .out_valid(out_valid), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Forwarding reference: returns {sel, data} for one register operand.
  function automatic logic [DW+1:0] ref_fwd(input stim_t s, input logic [AW-1:0] ad,
                                            input logic [DW-1:0] raw);
`ifdef ALU_OPERAND_FWD_EN
    if (s.exen && s.exad == ad) return {2'b01, s.exdt};
    if (s.wben && s.wbad == ad) return {2'b10, s.wbdt};
`endif
    return {2'b00, raw};
  endfunction

  function automatic out_t ref_next(input stim_t s, input out_t cur);
    out_t n;
    logic [DW+1:0] ra, rb;
    n = '0;
    if (s.fls) return n;
    if (s.stl) return cur;
    if (!s.vld) return n;
    ra = ref_fwd(s, s.rs, s.rda);
    rb = ref_fwd(s, s.rt, s.rdb);
    n.v  = 1'b1;
    n.m  = rb[DW-1:0];
    n.sa = ra[DW+1:DW];
    n.sb = rb[DW+1:DW];
    case (s.src)
      3'b001: begin n.a = ra[DW-1:0]; n.b = rb[DW-1:0]; end
      3'b010: begin n.a = ra[DW-1:0]; n.b = s.imm;      end
      3'b011: begin n.a = ra[DW-1:0]; n.b = '0;         end
      3'b100: begin n.a = s.imm;      n.b = '0;         end
      3'b101: begin n.a = rb[DW-1:0]; n.b = ra[DW-1:0]; end
      3'b110: begin n.a = s.pcv;      n.b = s.imm;      end
      default: begin n.a = '0;        n.b = '0;         end
    endcase
    return n;
  endfunction

  task automatic compare_outputs(input string tag, input out_t e);
    check({tag, ".valid"},     32'(out_valid), 32'(e.v));
    check({tag, ".a"},         32'(srcdata_a), 32'(e.a));
    check({tag, ".b"},         32'(srcdata_b), 32'(e.b));
    check({tag, ".memdata"},   32'(memdata),   32'(e.m));
    check({tag, ".fwd_sel_a"}, 32'(fwd_sel_a), 32'(e.sa));
    check({tag, ".fwd_sel_b"}, 32'(fwd_sel_b), 32'(e.sb));
  endtask

  // Apply one cycle of stimulus, push the prediction, then pop and compare.
  task automatic drive(input string tag, input stim_t s);
    out_t e;
    @(negedge clk);
    alu_src = s.src; in_valid = s.vld; stall = s.stl; flush = s.fls;
    rs_addr = s.rs; rt_addr = s.rt; read_data_A = s.rda; read_data_B = s.rdb;
    immediate = s.imm; pc = s.pcv;
    exmem_wr_en = s.exen; exmem_wr_addr = s.exad; exmem_wr_data = s.exdt;
    memwb_wr_en = s.wben; memwb_wr_addr = s.wbad; memwb_wr_data = s.wbdt;
    exp_q = ref_next(s, exp_q);
    sb_q.push_back(exp_q);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      compare_outputs(tag, e);
    end
  endtask

  function automatic stim_t base(input logic [2:0] src, input logic vld);
    stim_t s;
    s = '0;
    s.src = src;
    s.vld = vld;
    return s;
  endfunction

  function automatic stim_t rnd_stim();
    stim_t s;
    s.src  = 3'($urandom_range(0, 7));
    s.vld  = ($urandom_range(0, 3) != 0);
    s.stl  = ($urandom_range(0, 4) == 0);
    s.fls  = ($urandom_range(0, 9) == 0);
    s.rs   = AW'($urandom_range(0, 3));
    s.rt   = AW'($urandom_range(0, 3));
    s.rda  = DW'($urandom);
    s.rdb  = DW'($urandom);
    s.imm  = DW'($urandom);
    s.pcv  = DW'($urandom);
    s.exen = 1'($urandom);
    s.exad = AW'($urandom_range(0, 3));
    s.exdt = DW'($urandom);
    s.wben = 1'($urandom);
    s.wbad = AW'($urandom_range(0, 3));
    s.wbdt = DW'($urandom);
    return s;
  endfunction

  initial begin
    stim_t s;

    // Reset state with valid-looking inputs present.
    in_valid = 1'b1; alu_src = 3'b001; read_data_A = 16'hDEAD;
    #1;
    compare_outputs("reset", '0);
    @(posedge clk); #1;
    compare_outputs("reset_held", '0);
    @(negedge clk);
    rst = 1'b0;

    // Plain register operands, no write-backs.
    s = base(3'b001, 1'b1);
    s.rs = 4'd3; s.rt = 4'd4; s.rda = 16'h1111; s.rdb = 16'h2222;
    drive("r1_r2", s);

    // Both paths target r5: EX/MEM must win.
    s = base(3'b010, 1'b1);
    s.rs = 4'd5; s.rt = 4'd6; s.rda = 16'h5555; s.rdb = 16'h6666; s.imm = 16'h0010;
    s.exen = 1'b1; s.exad = 4'd5; s.exdt = 16'hAAAA;
    s.wben = 1'b1; s.wbad = 4'd5; s.wbdt = 16'hBBBB;
    drive("r1_im_fwd", s);

    // Swapped operands with MEM/WB forwarding on rt.
    s = base(3'b101, 1'b1);
    s.rs = 4'd1; s.rt = 4'd2; s.rda = 16'h1234; s.rdb = 16'h3333;
    s.wben = 1'b1; s.wbad = 4'd2; s.wbdt = 16'h00FF;
    drive("r2_r1_fwd", s);

    // Forwarding to index 0 is not suppressed.
    s = base(3'b011, 1'b1);
    s.rs = 4'd0; s.rda = 16'h0F0F;
    s.exen = 1'b1; s.exad = 4'd0; s.exdt = 16'hC0DE;
    drive("r1_nu_r0", s);

    s = base(3'b100, 1'b1);
    s.imm = 16'h7E57; s.rdb = 16'h4444;
    drive("im_nu", s);

    // Load, then stall three cycles with changing inputs, then stall+flush.
    s = base(3'b001, 1'b1);
    s.rs = 4'd1; s.rt = 4'd2; s.rda = 16'h0001; s.rdb = 16'h0002;
    drive("pre_stall", s);
    for (int i = 0; i < 3; i++) begin
      s = rnd_stim();
      s.stl = 1'b1; s.fls = 1'b0;
      drive("stall_hold", s);
    end
    s = rnd_stim();
    s.stl = 1'b1; s.fls = 1'b1; s.vld = 1'b1;
    drive("stall_flush", s);

    // PC/immediate, reserved code with and without in_valid, idle slot.
    s = base(3'b110, 1'b1);
    s.pcv = 16'h0040; s.imm = 16'hFFFE;
    drive("pc_im", s);
    s = base(3'b111, 1'b1);
    s.rda = 16'h9999; s.rdb = 16'h8888; s.imm = 16'h7777;
    drive("rsvd_valid", s);
    s = base(3'b111, 1'b0);
    drive("rsvd_invalid", s);
    s = base(3'b001, 1'b1);
    s.rda = 16'hAB00; s.rdb = 16'h00CD;
    drive("reload", s);
    s = base(3'b001, 1'b0);
    s.rda = 16'h1357; s.rdb = 16'h2468;
    drive("bubble", s);

    // Asynchronous reset mid-operation with out_valid=1.
    s = base(3'b001, 1'b1);
    s.rda = 16'h4242; s.rdb = 16'h2424;
    drive("pre_rst", s);
    #2;
    rst = 1'b1;
    #1;
    compare_outputs("rst_async", '0);
    exp_q = '0;
    @(posedge clk); #1;
    compare_outputs("rst_async_held", '0);
    @(negedge clk);
    rst = 1'b0;
    s = base(3'b010, 1'b1);
    s.rda = 16'h00AA; s.imm = 16'h0055;
    drive("post_rst", s);

    // Random traffic over a small register window to provoke matches.
    for (int i = 0; i < 60; i++) begin
      s = rnd_stim();
      drive("random", s);
    end

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
